merge_poly: RTL

//  Re-assembles a GF(2^m) polynomial from its even/odd coefficient fragments.
//  - Exact inverse of the split stage: merge(split(p)) == p for every p.
//  - Coefficient-pair serial: one even/odd pair per clock.
//  - Sits after the per-fragment arithmetic (sqrt/mult units) in the Patterson decode datapath of the ALU.

---
 rtl/poly_pkg.sv | 14 +
 rtl/merge_fsm.sv | 65 ++++++
 rtl/merge_poly.sv | 60 ++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared constants and merge FSM encoding for the polynomial split/merge stages.
package poly_pkg;
  localparam int COEF_W = 12;
  localparam int N_COEF = 12;
  localparam int DAT_W  = COEF_W * N_COEF;
  localparam int N_PAIR = N_COEF / 2;
  localparam int CNT_W  = $clog2(N_PAIR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } merge_state_t;
endpackage

// File: rtl/merge_fsm.sv
// Control for merge_poly: state register, pair counter, busy/done flags and datapath strobes.
module merge_fsm
  import poly_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  output logic busy,
  output logic done,
  output logic cap,
  output logic step,
  output logic load
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PAIR - 1);

  merge_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
  assign cap  = start && ((r_state == IDLE) || (r_state == DONE));
  assign step = (r_state == MERGE);
  assign load = step && (r_cnt == LAST);
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          r_cnt  <= '0;
          if (start) begin
            r_state <= MERGE;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        MERGE: begin
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/merge_poly.sv
// Re-interleaves even/odd coefficient fragments into one GF(2^m) polynomial, one pair per clock.
module merge_poly
  import poly_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [0:DAT_W-1] first_fragment_in,
  input  logic [0:DAT_W-1] second_fragment_in,
  output logic [0:DAT_W-1] poly_out,
  output logic             busy,
  output logic             done
);
  logic             w_cap;
  logic             w_step;
  logic             w_load;
  logic [0:DAT_W-1] r_f1;
  logic [0:DAT_W-1] r_f2;
  logic [0:DAT_W-1] r_asm;
  logic [0:DAT_W-1] r_poly;
  logic [0:2*COEF_W-1] w_pair;
  logic [0:DAT_W-1] w_asm_next;

  merge_fsm u_fsm (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .busy  (busy),
    .done  (done),
    .cap   (w_cap),
    .step  (w_step),
    .load  (w_load)
  );

  // Slot 0 of each fragment register is the current pair; appending on the right
  // leaves the first pair leftmost once all N_PAIR pairs are in.
  assign w_pair     = {r_f1[0:COEF_W-1], r_f2[0:COEF_W-1]};
  assign w_asm_next = {r_asm[2*COEF_W:DAT_W-1], w_pair};
  assign poly_out   = r_poly;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_f1   <= '0;
      r_f2   <= '0;
      r_asm  <= '0;
      r_poly <= '0;
    end else begin
      if (w_cap) begin
        r_f1  <= first_fragment_in;
        r_f2  <= second_fragment_in;
        r_asm <= '0;
      end else if (w_step) begin
        r_f1  <= {r_f1[COEF_W:DAT_W-1], {COEF_W{1'b0}}};
        r_f2  <= {r_f2[COEF_W:DAT_W-1], {COEF_W{1'b0}}};
        r_asm <= w_asm_next;
      end
      if (w_load) r_poly <= w_asm_next;
    end
  end
endmodule
